// File: rtl/poly_solver.sv
// Sequential root search: scans x in [x_lo, x_hi] with a Horner engine, stopping at the first P(x) == target (mod 2^SW).
// Optional abort input is compiled in when POLY_SOLVER_ABORT_EN is defined.
module poly_solver #(
  parameter int DEGREE = 10,
  parameter int XW     = 16,
  parameter int CW     = 16,
  parameter int SW     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(DEGREE+1)*CW-1:0] coeff,
  input  logic [SW-1:0]            target,
  input  logic [XW-1:0]            x_lo,
  input  logic [XW-1:0]            x_hi,
`ifdef POLY_SOLVER_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [XW-1:0]            x_out,
  output logic [XW:0]              eval_count
);

  localparam int KW = (DEGREE > 1) ? $clog2(DEGREE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EVAL  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [(DEGREE+1)*CW-1:0] coef_q;
  logic signed [SW-1:0]     target_q;
  logic signed [XW-1:0]     x_hi_q;
  logic signed [XW-1:0]     x_cur;
  logic signed [SW-1:0]     acc;
  logic [KW-1:0]            k;
  logic signed [CW-1:0]     c_k;
  logic signed [CW-1:0]     c_top;
  logic                     hit;
  logic                     at_hi;
  logic                     abort_req;
  logic                     range_empty;

`ifdef POLY_SOLVER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // One Horner step; only the low SW bits of the product are kept, so the
  // whole step wraps mod 2^SW exactly like the truncated combinational sum.
  function automatic logic signed [SW-1:0] horner_step(
    input logic signed [SW-1:0] a,
    input logic signed [XW-1:0] x,
    input logic signed [CW-1:0] c
  );
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] c_ext;
    x_ext = {{(SW-XW){x[XW-1]}}, x};
    c_ext = {{(SW-CW){c[CW-1]}}, c};
    return a * x_ext + c_ext;
  endfunction

  assign c_k         = coef_q[k*CW +: CW];
  assign c_top       = coef_q[DEGREE*CW +: CW];
  assign hit         = (acc == target_q);
  assign at_hi       = (x_cur == x_hi_q);
  assign range_empty = ($signed(x_lo) > $signed(x_hi));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = range_empty ? FIN : INIT;
      INIT:  state_nxt = abort_req ? FIN : EVAL;
      EVAL: begin
        if (abort_req)     state_nxt = FIN;
        else if (k == '0)  state_nxt = CHECK;
      end
      // A hit takes priority over a simultaneous abort.
      CHECK: state_nxt = (hit || abort_req || at_hi) ? FIN : INIT;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done is registered from FIN, so it pulses in the cycle after FIN with busy already low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q     <= '0;
      target_q   <= '0;
      x_hi_q     <= '0;
      x_cur      <= '0;
      acc        <= '0;
      k          <= '0;
      done       <= 1'b0;
      found      <= 1'b0;
      x_out      <= '0;
      eval_count <= '0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            coef_q     <= coeff;
            target_q   <= target;
            x_hi_q     <= x_hi;
            x_cur      <= x_lo;
            eval_count <= '0;
            found      <= 1'b0;
          end
        end
        INIT: begin
          acc <= {{(SW-CW){c_top[CW-1]}}, c_top};
          k   <= KW'(DEGREE - 1);
          if (abort_req) x_out <= x_cur;
        end
        EVAL: begin
          acc <= horner_step(acc, x_cur, c_k);
          k   <= k - KW'(1);
          if (abort_req) x_out <= x_cur;
        end
        CHECK: begin
          eval_count <= eval_count + (XW+1)'(1);
          if (hit) begin
            found <= 1'b1;
            x_out <= x_cur;
          end else if (abort_req || at_hi) begin
            found <= 1'b0;
            x_out <= x_cur;
          end else begin
            x_cur <= x_cur + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
